// File: rtl/mcs4_keyprt_pkg.sv
// Shared constants, key codes, FSM states and record type for the MCS-4 key/printer host.
package mcs4_keyprt_pkg;

   localparam int unsigned CMD_W       = 32;
   localparam int unsigned RES_W       = 32;
   localparam int unsigned CODE_W      = 7;
   localparam int unsigned ROW_W       = 4;
   localparam int unsigned COL_W       = 17;

   localparam int unsigned CMD_EN      = 31;
   localparam int unsigned CMD_POP     = 15;
   localparam int unsigned CMD_KEY     = 7;
   localparam logic [CMD_W-1:0] CMD_OFF = 32'h8000_0000;

   localparam int unsigned RES_ALIVE   = 31;
   localparam int unsigned RES_DV      = 0;
   localparam int unsigned RES_ROW_LSB = 10;
   localparam int unsigned RES_COL_LSB = 14;

   localparam logic [CODE_W-1:0] KEY_1     = 7'h1B;
   localparam logic [CODE_W-1:0] KEY_2     = 7'h17;
   localparam logic [CODE_W-1:0] KEY_3     = 7'h13;
   localparam logic [CODE_W-1:0] KEY_4     = 7'h1A;
   localparam logic [CODE_W-1:0] KEY_PLUS  = 7'h0E;
   localparam logic [CODE_W-1:0] KEY_MINUS = 7'h0D;
   localparam logic [CODE_W-1:0] KEY_EQ    = 7'h0C;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_KEY_ON   = 3'd1,
      ST_KEY_OFF  = 3'd2,
      ST_POP_WAIT = 3'd3,
      ST_POP_HOLD = 3'd4,
      ST_POP_OFF  = 3'd5
   } state_e;

   typedef struct packed {
      logic [ROW_W-1:0] row;
      logic [COL_W-1:0] col;
   } prt_rec_t;

   // Extract the printer row/column record from a response word.
   function automatic prt_rec_t res_to_rec(input logic [RES_W-1:0] res);
      prt_rec_t rec;
      rec.row = res[RES_ROW_LSB +: ROW_W];
      rec.col = res[RES_COL_LSB +: COL_W];
      return rec;
   endfunction

   // A response carries a record only when the system is alive and the FIFO had data.
   function automatic logic res_ok(input logic [RES_W-1:0] res);
      return res[RES_ALIVE] & res[RES_DV];
   endfunction

endpackage

// File: rtl/mcs4_keyprt_delay.sv
// Loadable down-counter shared by all timed FSM states; done_c marks the last cycle.
module mcs4_keyprt_delay #(
   parameter int unsigned CNT_W = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done_c
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // A load of L gives L cycles before done; zero is treated as one cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = (load_val == '0) ? '0 : load_val - CNT_W'(1);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_c = (cnt_q == '0);

endmodule

// File: rtl/mcs4_keyprt_host.sv
// Host controller: sequences key press/release and printer FIFO pops on the key/printer port.
module mcs4_keyprt_host
   import mcs4_keyprt_pkg::*;
#(
   parameter int unsigned KEY_HOLD = 50000,
   parameter int unsigned KEY_GAP  = 50000,
   parameter int unsigned RES_WAIT = 4,
   parameter int unsigned POP_HOLD = 10000,
   parameter int unsigned POP_GAP  = 10000,
   parameter int unsigned CNT_W    = 24
) (
   input  logic        CLK,
   input  logic        RES_N,
   input  logic        KEY_VALID,
   input  logic [6:0]  KEY_CODE,
   output logic        KEY_READY,
   input  logic        POLL_REQ,
   output logic        PRT_VALID,
   input  logic        PRT_READY,
   output logic [3:0]  PRT_ROW,
   output logic [16:0] PRT_COL,
   output logic        BUSY,
   output logic [31:0] PORT_KEYPRT_CMD,
   input  logic [31:0] PORT_KEYPRT_RES
);

   localparam longint unsigned CNT_LIM  = 64'd1 << CNT_W;
   localparam int unsigned     RES_EFF  = (RES_WAIT == 0) ? 1 : RES_WAIT;
   localparam int unsigned     POP_REST = (POP_HOLD > RES_EFF) ? POP_HOLD - RES_EFF : 1;

   // Every delay must be representable in the shared counter.
   if ((64'(KEY_HOLD) >= CNT_LIM) || (64'(KEY_GAP) >= CNT_LIM) || (64'(RES_WAIT) >= CNT_LIM) ||
       (64'(POP_HOLD) >= CNT_LIM) || (64'(POP_GAP) >= CNT_LIM)) begin : g_param_chk
      $error("mcs4_keyprt_host: delay parameter does not fit in CNT_W bits");
   end

   state_e              state_q, state_d;
   logic [CODE_W-1:0]   code_q, code_d;
   prt_rec_t            rec_q, rec_d;
   logic                prt_valid_q, prt_valid_d;
   logic                key_ready_q, key_ready_d;
   logic                busy_q, busy_d;
   logic [CMD_W-1:0]    cmd_q, cmd_d;
   logic                dly_load_c;
   logic [CNT_W-1:0]    dly_val_c;
   logic                dly_done_c;
   logic                res_unused_c;

   assign res_unused_c = ^PORT_KEYPRT_RES[RES_ROW_LSB-1:RES_DV+1];

   mcs4_keyprt_delay #(.CNT_W(CNT_W)) u_delay (
      .clk      (CLK),
      .rst_n    (RES_N),
      .load     (dly_load_c),
      .load_val (dly_val_c),
      .done_c   (dly_done_c)
   );

   // Next state, record capture, counter reload and next registered outputs.
   always_comb begin
      state_d     = state_q;
      code_d      = code_q;
      rec_d       = rec_q;
      prt_valid_d = prt_valid_q;
      cmd_d       = CMD_OFF;
      dly_val_c   = '0;

      if (prt_valid_q && PRT_READY) begin
         prt_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (key_ready_q) begin
               if (KEY_VALID) begin
                  code_d  = KEY_CODE;
                  state_d = ST_KEY_ON;
               end else if (POLL_REQ && !prt_valid_q) begin
                  state_d = ST_POP_WAIT;
               end
            end
         end
         ST_KEY_ON:   if (dly_done_c) state_d = ST_KEY_OFF;
         ST_KEY_OFF:  if (dly_done_c) state_d = ST_IDLE;
         ST_POP_WAIT: begin
            if (dly_done_c) begin
               if (res_ok(PORT_KEYPRT_RES)) begin
                  rec_d       = res_to_rec(PORT_KEYPRT_RES);
                  prt_valid_d = 1'b1;
               end
               state_d = ST_POP_HOLD;
            end
         end
         ST_POP_HOLD: if (dly_done_c) state_d = ST_POP_OFF;
         ST_POP_OFF:  if (dly_done_c) state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase

      dly_load_c = (state_d != state_q);

      case (state_d)
         ST_KEY_ON: begin
            dly_val_c               = CNT_W'(KEY_HOLD);
            cmd_d[CMD_KEY]          = 1'b1;
            cmd_d[CODE_W-1:0]       = code_d;
         end
         ST_KEY_OFF:  dly_val_c = CNT_W'(KEY_GAP);
         ST_POP_WAIT: begin
            dly_val_c      = CNT_W'(RES_WAIT);
            cmd_d[CMD_POP] = 1'b1;
         end
         ST_POP_HOLD: begin
            dly_val_c      = CNT_W'(POP_REST);
            cmd_d[CMD_POP] = 1'b1;
         end
         ST_POP_OFF:  dly_val_c = CNT_W'(POP_GAP);
         default:     dly_val_c = '0;
      endcase

      key_ready_d = (state_d == ST_IDLE);
      busy_d      = ~key_ready_d;
   end

   // State and output registers; reset aborts any sequence in flight.
   always_ff @(posedge CLK or negedge RES_N) begin
      if (!RES_N) begin
         state_q     <= ST_IDLE;
         code_q      <= '0;
         rec_q       <= '0;
         prt_valid_q <= 1'b0;
         key_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         cmd_q       <= '0;
      end else begin
         state_q     <= state_d;
         code_q      <= code_d;
         rec_q       <= rec_d;
         prt_valid_q <= prt_valid_d;
         key_ready_q <= key_ready_d;
         busy_q      <= busy_d;
         cmd_q       <= cmd_d;
      end
   end

   assign KEY_READY       = key_ready_q;
   assign PRT_VALID       = prt_valid_q;
   assign PRT_ROW         = rec_q.row;
   assign PRT_COL         = rec_q.col;
   assign BUSY            = busy_q;
   assign PORT_KEYPRT_CMD = cmd_q;

endmodule

// File: doc/mcs4_keyprt_host.md
# mcs4_keyprt_host

Host-side controller for the MCS-4 calculator key/printer port. It converts a stream of key codes into correctly timed press/release commands on `PORT_KEYPRT_CMD`. It drains the printer FIFO by issuing pop commands and sampling `PORT_KEYPRT_RES`, then returns each printed row as a ready/valid record. It sits between the host MCU (UI) logic and `MCS4_SYS`, replacing hand-driven command sequencing.

## Interface
- `KEY_HOLD`, 50000: cycles a key command is held asserted.
- `KEY_GAP`, 50000: cycles of OFF after key release before the next action.
- `RES_WAIT`, 4: cycles from pop assertion to response sample.
- `POP_HOLD`, 10000: total cycles the pop command is held, counted from pop assertion.
- `POP_GAP`, 10000: cycles of OFF after a pop.
- `CNT_W`, 24: delay counter width. Every delay parameter must be < 2^CNT_W; an assertion checks this.
- `CLK` in 1: clock.
- `RES_N` in 1: reset. Decided: one clock; reset is asynchronous, active-low.
- `KEY_VALID` in 1: key request.
- `KEY_CODE` in 7: key code, e.g. 1=0x1B, 2=0x17, 3=0x13, 4=0x1A, +=0x0E, -=0x0D, ==0x0C.
- `KEY_READY` out 1: key request accepted this cycle.
- `POLL_REQ` in 1: level; while high, drain the printer FIFO.
- `PRT_VALID` out 1: printer record available.
- `PRT_READY` in 1: record consumed.
- `PRT_ROW` out 4: printer row (drum sector) number.
- `PRT_COL` out 17: column hammer bits.
- `BUSY` out 1: FSM not in IDLE.
- `PORT_KEYPRT_CMD` out 32: command to `MCS4_SYS`.
- `PORT_KEYPRT_RES` in 32: response from `MCS4_SYS`.

## Operation
- Command word fields:
  - [31] = enable.
  - [15] = FIFO pop.
  - [7] = key strobe.
  - [6:0] = key code.
  - OFF = 0x8000_0000.
  - Key press = 0x8000_0080 | code.
  - Pop = 0x8000_8000.
- Response word fields:
  - [31] = alive.
  - [30:14] = COL.
  - [13:10] = ROW.
  - [0] = data valid.
  - A record is accepted only if [31]=1 and [0]=1.
- FSM states: IDLE, KEY_ON, KEY_OFF, POP_WAIT, POP_HOLD, POP_OFF.
- IDLE: CMD = OFF. `KEY_READY` = 1 in IDLE.
  - If `KEY_VALID`=1: latch the code, go to KEY_ON. Keys take priority over polling.
  - Else if `POLL_REQ`=1 and `PRT_VALID`=0: go to POP_WAIT.
- KEY_ON: CMD = 0x8000_0080|code for `KEY_HOLD` cycles, then KEY_OFF.
- KEY_OFF: CMD = OFF for `KEY_GAP` cycles, then IDLE.
- POP_WAIT: CMD = pop. After `RES_WAIT` cycles, sample RES.
  - Valid sample: load `PRT_ROW`/`PRT_COL` and set `PRT_VALID`.
  - Then go to POP_HOLD.
- POP_HOLD: CMD = pop until a total of `POP_HOLD` cycles since pop assertion, then POP_OFF.
- POP_OFF: CMD = OFF for `POP_GAP` cycles, then IDLE.
- `PRT_VALID` holds, with stable data, until `PRT_READY`=1. It clears on the cycle after the handshake. Key traffic may proceed while a record is pending; pops may not.
- An invalid sample (FIFO empty, or [31]=0) produces no record. The pop sequence still completes; `POLL_REQ` remaining high retries after POP_OFF.
- `KEY_VALID` and `POLL_REQ` high together in IDLE: the key wins, and the poll is taken on the next IDLE.

## Timing
- Reset (async, `RES_N`=0):
  - CMD = 0x0000_0000.
  - `KEY_READY`=0, `PRT_VALID`=0, `PRT_ROW`=0, `PRT_COL`=0, `BUSY`=0.
  - FSM = IDLE, counters = 0.
  - Reset mid-sequence aborts it. No record is emitted and the latched key is discarded.
- The first cycle after reset release drives OFF. All outputs are registered.
- Key acceptance: handshake at edge N. CMD shows the key from N+1 through N+`KEY_HOLD`, then OFF for `KEY_GAP` cycles. The next `KEY_READY` is asserted at N+`KEY_HOLD`+`KEY_GAP`+1.
- Pop: first pop cycle P. RES is sampled at edge P+`RES_WAIT`; `PRT_VALID` rises at P+`RES_WAIT`+1. Pop is deasserted after `POP_HOLD` total cycles.
- A zero-length parameter is treated as 1 cycle.
- Counters reload at each state entry. There is no wrap-around, because delays are bounded by `CNT_W`.

## Structure
- Package `mcs4_keyprt_pkg` holds:
  - Field positions and constants: `CMD_EN`=31, `CMD_POP`=15, `CMD_KEY`=7, `CMD_OFF`=32'h8000_0000, `RES_ROW_LSB`=10, `RES_COL_LSB`=14.
  - Key-code localparams.
  - The FSM state enum.
- One sub-module, `mcs4_keyprt_delay`: loadable down-counter with a `done` pulse, instantiated once and shared by all timed states.

## Test plan
- Key '1': KEY_CODE=0x1B → CMD=0x8000_009B for exactly 50000 cycles, then 0x8000_0000 for 50000 cycles, then `KEY_READY` returns.
- Key sequence 1,2,+,3,4,+,= back-to-back with `KEY_VALID` held → seven press windows, codes in order, no overlap.
- Pop, with the model returning 0x8002_8401 at RES_WAIT → `PRT_ROW`=1, `PRT_COL`=0x0000A. `PRT_VALID` stays high with `PRT_READY`=0 for 100 cycles, and no new pop is issued.
- Drain, with model responses 0x8000_2C01, 0x8000_3001, then 0x8000_0000 (empty) → records ROW 11 and ROW 12 are delivered. The third pop emits nothing, and retries while `POLL_REQ`=1.
- `KEY_VALID` and `POLL_REQ` asserted together → the key sequence is issued first, then the pop.
- `RES_N` low during KEY_ON → CMD=0x0000_0000 immediately, asynchronously. After release: IDLE, CMD=OFF, no record.
